// File: rtl/branch_ctrl.sv
// Execute-stage branch resolution for the npc core: latches one branch from ID,
// resolves it on the comparator, redirects the IFU when taken, then returns a result record.

module branch_cmp (
  input  logic [2:0]  fn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        res
);
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    res = 1'b0;
    case (fn)
      3'b000:  res = (a == b);
      3'b001:  res = (a != b);
      3'b011:  res = (a_s < b_s);
      3'b010:  res = (a_s >= b_s);
      3'b101:  res = (a < b);
      3'b110:  res = (a >= b);
      default: res = 1'b0;
    endcase
  end
endmodule

module branch_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] imm_i,
  input  logic [2:0]  funct3_i,
  output logic        redir_valid_o,
  input  logic        redir_ready_i,
  output logic [31:0] redir_pc_o,
  output logic        flush_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        taken_o,
  output logic        err_o,
  output logic [31:0] taken_cnt_o
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, EVAL, REDIR, RESP} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] pc_p0, rs1_p0, rs2_p0, imm_p0;
  logic [2:0]        f3_p0;
  logic [DATA_W-1:0] tgt_p0;
  logic [2:0]        cmp_fn_p0;
  logic              fn_legal_p0;
  logic              cmp_res_p0;
  logic              br_taken_p0;

  logic [DATA_W-1:0] tgt_p1;
  logic              taken_p1;
  logic              err_p1;

  logic [31:0]       taken_cnt;
  logic              accept;
  logic              redir_fire;

  // Returns {legal, fn}; funct3 010/011 have no comparator encoding.
  function automatic logic [3:0] map_fn(input logic [2:0] f3);
    case (f3)
      3'b000:  map_fn = {1'b1, 3'b000};
      3'b001:  map_fn = {1'b1, 3'b001};
      3'b100:  map_fn = {1'b1, 3'b011};
      3'b101:  map_fn = {1'b1, 3'b010};
      3'b110:  map_fn = {1'b1, 3'b101};
      3'b111:  map_fn = {1'b1, 3'b110};
      default: map_fn = {1'b0, 3'b000};
    endcase
  endfunction

  assign {fn_legal_p0, cmp_fn_p0} = map_fn(f3_p0);
  assign tgt_p0      = pc_p0 + imm_p0;
  assign br_taken_p0 = fn_legal_p0 & cmp_res_p0;

  branch_cmp u_cmp (
    .fn  (cmp_fn_p0),
    .a   (rs1_p0),
    .b   (rs2_p0),
    .res (cmp_res_p0)
  );

  assign accept     = in_ready_o & in_valid_i;
  assign redir_fire = (state == REDIR) & redir_ready_i & ~flush_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid_i) state_nxt = EVAL;
        EVAL: begin
          if (br_taken_p0 && (tgt_p0[1:0] == 2'b00)) state_nxt = REDIR;
          else                                       state_nxt = RESP;
        end
        REDIR:   if (redir_ready_i) state_nxt = RESP;
        RESP:    if (out_ready_i) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand capture on accept (p0), resolved record at the end of EVAL (p1).
  always_ff @(posedge clk_i) begin
    if (accept) begin
      pc_p0  <= pc_i;
      rs1_p0 <= rs1_i;
      rs2_p0 <= rs2_i;
      imm_p0 <= imm_i;
      f3_p0  <= funct3_i;
    end
    if (state == EVAL) begin
      tgt_p1   <= tgt_p0;
      taken_p1 <= br_taken_p0;
      err_p1   <= ~fn_legal_p0 | (br_taken_p0 & (tgt_p0[1:0] != 2'b00));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)           taken_cnt <= '0;
    else if (redir_fire) taken_cnt <= taken_cnt + 32'd1;
  end

  assign taken_cnt_o = taken_cnt;

  // Record outputs are masked by state so they read zero outside their phase.
  always_comb begin
    in_ready_o    = 1'b0;
    redir_valid_o = 1'b0;
    redir_pc_o    = '0;
    flush_o       = 1'b0;
    out_valid_o   = 1'b0;
    taken_o       = 1'b0;
    err_o         = 1'b0;
    case (state)
      IDLE:  in_ready_o = ~flush_i & ~rst_i;
      REDIR: begin
        redir_valid_o = 1'b1;
        redir_pc_o    = tgt_p1;
        flush_o       = redir_fire;
      end
      RESP: begin
        out_valid_o = 1'b1;
        taken_o     = taken_p1;
        err_o       = err_p1;
      end
      default: ;
    endcase
  end

  a_flush_in_redir: assert property (@(posedge clk_i) disable iff (rst_i)
    flush_o |-> redir_valid_o);

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: hand-computed expectations for every resolution path,
// handshake stalls, flush and mid-operation reset.

module tb_branch_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] pc_i, rs1_i, rs2_i, imm_i;
  logic [2:0]  funct3_i;
  logic        redir_valid_o;
  logic        redir_ready_i;
  logic [31:0] redir_pc_o;
  logic        flush_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        taken_o;
  logic        err_o;
  logic [31:0] taken_cnt_o;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_cnt = 32'd0;

  branch_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .pc_i         (pc_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .imm_i        (imm_i),
    .funct3_i     (funct3_i),
    .redir_valid_o(redir_valid_o),
    .redir_ready_i(redir_ready_i),
    .redir_pc_o   (redir_pc_o),
    .flush_o      (flush_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .taken_o      (taken_o),
    .err_o        (err_o),
    .taken_cnt_o  (taken_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a branch in the current IDLE cycle; returns in the EVAL cycle.
  task automatic accept(input string tag, input logic [31:0] pc, rs1, rs2, imm,
                        input logic [2:0] f3);
    pc_i = pc; rs1_i = rs1; rs2_i = rs2; imm_i = imm; funct3_i = f3;
    in_valid_i = 1'b1;
    #1;
    check({tag, ":in_ready"}, 32'(in_ready_o), 32'd1);
    tick();
    in_valid_i = 1'b0;
    check({tag, ":eval_busy"}, 32'(in_ready_o), 32'd0);
    check({tag, ":eval_noout"}, 32'({redir_valid_o, out_valid_o, flush_o}), 32'd0);
  endtask

  task automatic do_branch(input string tag, input logic [31:0] pc, rs1, rs2, imm,
                           input logic [2:0] f3, input logic exp_tk, exp_er, exp_rd,
                           input logic [31:0] exp_tgt);
    accept(tag, pc, rs1, rs2, imm, f3);
    tick();
    if (exp_rd) begin
      check({tag, ":redir_valid"}, 32'(redir_valid_o), 32'd1);
      check({tag, ":redir_pc"}, redir_pc_o, exp_tgt);
      check({tag, ":flush"}, 32'(flush_o), 32'd1);
      exp_cnt = exp_cnt + 32'd1;
      tick();
      check({tag, ":flush_off"}, 32'(flush_o), 32'd0);
    end else begin
      check({tag, ":no_redir"}, 32'({redir_valid_o, flush_o}), 32'd0);
    end
    check({tag, ":out_valid"}, 32'(out_valid_o), 32'd1);
    check({tag, ":taken"}, 32'(taken_o), 32'(exp_tk));
    check({tag, ":err"}, 32'(err_o), 32'(exp_er));
    check({tag, ":cnt"}, taken_cnt_o, exp_cnt);
    tick();
    check({tag, ":idle"}, 32'({in_ready_o, out_valid_o}), 32'b10);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0;
    pc_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0; funct3_i = '0;
    redir_ready_i = 1'b1; out_ready_i = 1'b1;

    tick();
    check("rst:in_ready_low", 32'(in_ready_o), 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    check("rst:in_ready", 32'(in_ready_o), 32'd1);
    check("rst:valids", 32'({redir_valid_o, flush_o, out_valid_o, taken_o, err_o}), 32'd0);
    check("rst:redir_pc", redir_pc_o, 32'd0);
    check("rst:cnt", taken_cnt_o, 32'd0);

    //            tag    pc            rs1           rs2           imm           f3      tk    er    rd    target
    do_branch("beq",    32'h80000000, 32'h00001234, 32'h00001234, 32'h00000010, 3'b000, 1'b1, 1'b0, 1'b1, 32'h80000010);
    do_branch("blt",    32'h00000100, 32'hFFFFFFFF, 32'h00000001, 32'h00000020, 3'b100, 1'b1, 1'b0, 1'b1, 32'h00000120);
    do_branch("bltu",   32'h00000100, 32'hFFFFFFFF, 32'h00000001, 32'h00000020, 3'b110, 1'b0, 1'b0, 1'b0, 32'h0);
    do_branch("bgeu",   32'h00000200, 32'hFFFFFFFF, 32'h00000001, 32'h00000040, 3'b111, 1'b1, 1'b0, 1'b1, 32'h00000240);
    do_branch("bge",    32'h00000200, 32'hFFFFFFFF, 32'h00000001, 32'h00000040, 3'b101, 1'b0, 1'b0, 1'b0, 32'h0);
    do_branch("bne_nt", 32'h00000300, 32'h00000005, 32'h00000005, 32'h00000008, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0);
    do_branch("bne_t",  32'h00000300, 32'h00000005, 32'h00000006, 32'h00000008, 3'b001, 1'b1, 1'b0, 1'b1, 32'h00000308);
    do_branch("illegal",32'h00000400, 32'h00000007, 32'h00000007, 32'h00000010, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0);
    do_branch("misalign",32'h00001000,32'h00000003, 32'h00000003, 32'h00000006, 3'b000, 1'b1, 1'b1, 1'b0, 32'h0);
    do_branch("wrap",   32'hFFFFFFF0, 32'h00000000, 32'h00000000, 32'h00000020, 3'b000, 1'b1, 1'b0, 1'b1, 32'h00000010);
    do_branch("negimm", 32'h00002000, 32'h00000009, 32'h00000009, 32'hFFFFFFF8, 3'b000, 1'b1, 1'b0, 1'b1, 32'h00001FF8);

    // Redirect stall then result stall.
    redir_ready_i = 1'b0;
    accept("stall", 32'h00003000, 32'h1, 32'h1, 32'h00000100, 3'b000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall:redir_valid", 32'(redir_valid_o), 32'd1);
      check("stall:redir_pc", redir_pc_o, 32'h00003100);
      check("stall:no_flush", 32'(flush_o), 32'd0);
      check("stall:cnt_hold", taken_cnt_o, exp_cnt);
    end
    redir_ready_i = 1'b1;
    #1;
    check("stall:flush", 32'(flush_o), 32'd1);
    exp_cnt = exp_cnt + 32'd1;
    out_ready_i = 1'b0;
    tick();
    check("stall:cnt_once", taken_cnt_o, exp_cnt);
    for (int i = 0; i < 4; i++) begin
      check("ostall:in_ready", 32'(in_ready_o), 32'd0);
      check("ostall:out", 32'({out_valid_o, taken_o, err_o}), 32'b110);
      tick();
    end
    check("ostall:cnt", taken_cnt_o, exp_cnt);
    out_ready_i = 1'b1;
    tick();
    check("ostall:idle", 32'(in_ready_o), 32'd1);

    // Flush wins over a simultaneous redirect handshake.
    accept("fl_redir", 32'h00004000, 32'h2, 32'h2, 32'h00000010, 3'b000);
    tick();
    flush_i = 1'b1;
    #1;
    check("fl_redir:flush_o", 32'(flush_o), 32'd0);
    tick();
    flush_i = 1'b0;
    #1;
    check("fl_redir:idle", 32'({in_ready_o, redir_valid_o, out_valid_o}), 32'b100);
    check("fl_redir:cnt", taken_cnt_o, exp_cnt);

    // Flush during EVAL produces nothing.
    accept("fl_eval", 32'h00005000, 32'h3, 32'h3, 32'h00000010, 3'b000);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    check("fl_eval:idle", 32'({in_ready_o, redir_valid_o, out_valid_o}), 32'b100);
    tick();
    check("fl_eval:quiet", 32'({redir_valid_o, out_valid_o, flush_o}), 32'd0);

    // Flush in IDLE blocks a simultaneous offer.
    in_valid_i = 1'b1;
    flush_i = 1'b1;
    #1;
    check("fl_idle:in_ready", 32'(in_ready_o), 32'd0);
    tick();
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    #1;
    check("fl_idle:not_accepted", 32'(in_ready_o), 32'd1);

    // Reset while holding a result in RESP.
    out_ready_i = 1'b0;
    accept("rst_mid", 32'h00006000, 32'h4, 32'h4, 32'h00000010, 3'b000);
    tick();
    exp_cnt = exp_cnt + 32'd1;
    tick();
    check("rst_mid:resp", 32'(out_valid_o), 32'd1);
    check("rst_mid:cnt_pre", taken_cnt_o, exp_cnt);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    #1;
    exp_cnt = 32'd0;
    check("rst_mid:outs", 32'({redir_valid_o, flush_o, out_valid_o, taken_o, err_o}), 32'd0);
    check("rst_mid:redir_pc", redir_pc_o, 32'd0);
    check("rst_mid:cnt", taken_cnt_o, 32'd0);
    check("rst_mid:in_ready", 32'(in_ready_o), 32'd1);
    do_branch("post_rst", 32'h00007000, 32'h8, 32'h8, 32'h00000004, 3'b000, 1'b1, 1'b0, 1'b1, 32'h00007004);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
